pll_lock_supervisor: RTL and testbench



---
 rtl/pll_sup_pkg.sv | 36 +++
 rtl/sync_bit.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 150 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

    // Supervisor states; any encoding outside this set is treated as PLL_RST.
    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } sup_state_e;

    localparam int DEF_RST_PULSE_CYC    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 500000;
    localparam int DEF_STABLE_CYC       = 1024;
    localparam int DEF_MAX_RETRY        = 7;
    localparam int DEF_SYNC_STAGES      = 2;

    // Width of the shared cycle counter: large enough for the longest interval, plus one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to 0.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic refclk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge refclk) begin
        if (rst) begin
            chain_r <= '0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: sequences the PLL reset, qualifies lock, gates the core reset.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int STABLE_CYC       = DEF_STABLE_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY,
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked_in,
    output logic       pll_rst_out,
    output logic       sys_rst_out,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] lost_lock_count
);

    localparam int CW = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
    // The WAIT_LOCK cycle that first sees lk=1 counts as the first stable cycle,
    // so STABLE needs STABLE_CYC-1 further locked cycles before release.
    localparam logic [CW-1:0] STABLE_LAST  = CW'((STABLE_CYC >= 2) ? (STABLE_CYC - 2) : 0);
    localparam logic [3:0]    MAX_RETRY_V  = 4'(MAX_RETRY);

    logic          lk_s;
    sup_state_e    state_r;
    sup_state_e    state_next_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic [3:0]    retry_next_s;
    logic [3:0]    retry_inc_s;
    logic          lost_inc_s;
    logic [7:0]    lost_next_s;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .refclk (refclk),
        .rst    (rst),
        .d      (pll_locked_in),
        .q      (lk_s)
    );

    assign retry_inc_s = retry_count + 4'd1;

    // Next-state, counter and event decode for the bring-up sequence.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        retry_next_s = retry_count;
        lost_inc_s   = 1'b0;
        case (state_r)
            PLL_RST: begin
                if (cnt_r == RST_LAST) begin
                    state_next_s = WAIT_LOCK;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = PLL_RST;
                end
            end
            WAIT_LOCK: begin
                if (lk_s) begin
                    // Lock wins over a coincident timeout.
                    state_next_s = STABLE;
                    cnt_next_s   = '0;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    retry_next_s = retry_inc_s;
                    cnt_next_s   = '0;
                    if (retry_inc_s == MAX_RETRY_V) begin
                        state_next_s = FAULT;
                    end else begin
                        state_next_s = PLL_RST;
                    end
                end else begin
                    state_next_s = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    // Glitch: back to waiting with a fresh timeout, no retry charged.
                    state_next_s = WAIT_LOCK;
                    cnt_next_s   = '0;
                end else if (cnt_r == STABLE_LAST) begin
                    state_next_s = RUN;
                    cnt_next_s   = '0;
                    retry_next_s = 4'd0;
                end else begin
                    state_next_s = STABLE;
                end
            end
            RUN: begin
                cnt_next_s = '0;
                if (!lk_s) begin
                    state_next_s = PLL_RST;
                    lost_inc_s   = 1'b1;
                end else begin
                    state_next_s = RUN;
                end
            end
            FAULT: begin
                cnt_next_s   = '0;
                state_next_s = FAULT;
            end
            default: begin
                state_next_s = PLL_RST;
                cnt_next_s   = '0;
            end
        endcase
    end

    // Saturating lock-loss event counter.
    always_comb begin
        lost_next_s = lost_lock_count;
        if (lost_inc_s && (lost_lock_count != 8'hFF)) begin
            lost_next_s = lost_lock_count + 8'd1;
        end else begin
            lost_next_s = lost_lock_count;
        end
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r         <= PLL_RST;
            cnt_r           <= '0;
            pll_rst_out     <= 1'b1;
            sys_rst_out     <= 1'b1;
            ready           <= 1'b0;
            fault           <= 1'b0;
            retry_count     <= 4'd0;
            lost_lock_count <= 8'd0;
        end else begin
            state_r         <= state_next_s;
            cnt_r           <= cnt_next_s;
            pll_rst_out     <= (state_next_s == PLL_RST) || (state_next_s == FAULT);
            sys_rst_out     <= (state_next_s != RUN);
            ready           <= (state_next_s == RUN);
            fault           <= (state_next_s == FAULT);
            retry_count     <= retry_next_s;
            lost_lock_count <= lost_next_s;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst;
    logic       pll_locked_in;
    logic       pll_rst_out;
    logic       sys_rst_out;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] lost_lock_count;

    int e;
    int base;
    int errors;
    int checks;

    pll_lock_supervisor #(
        .RST_PULSE_CYC    (4),
        .LOCK_TIMEOUT_CYC (20),
        .STABLE_CYC       (8),
        .MAX_RETRY        (3),
        .SYNC_STAGES      (2)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .pll_locked_in   (pll_locked_in),
        .pll_rst_out     (pll_rst_out),
        .sys_rst_out     (sys_rst_out),
        .ready           (ready),
        .fault           (fault),
        .retry_count     (retry_count),
        .lost_lock_count (lost_lock_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Advance one edge; sample and drive 1 time unit after it.
    task automatic step();
        @(posedge refclk);
        #1;
        e = e + 1;
    endtask

    task automatic to(input int t);
        while (e < t) begin
            step();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, e - base);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"}, {31'd0, pll_rst_out}, 32'd1);
        chk({tag, "_sys_rst"}, {31'd0, sys_rst_out}, 32'd1);
        chk({tag, "_ready"},   {31'd0, ready},       32'd0);
        chk({tag, "_fault"},   {31'd0, fault},       32'd0);
        chk({tag, "_retry"},   {28'd0, retry_count}, 32'd0);
        chk({tag, "_lost"},    {24'd0, lost_lock_count}, 32'd0);
    endtask

    // Rst is sampled high at edge base+0 and low from base+1; lock raised after base+10.
    task automatic nominal(input string tag);
        base = e;
        rst = 1'b0;
        to(base + 3);
        chk({tag, "_pll_rst_e3"}, {31'd0, pll_rst_out}, 32'd1);
        to(base + 4);
        chk({tag, "_pll_rst_e4"}, {31'd0, pll_rst_out}, 32'd0);
        to(base + 10);
        pll_locked_in = 1'b1;
        to(base + 19);
        chk({tag, "_sys_rst_e19"}, {31'd0, sys_rst_out}, 32'd1);
        chk({tag, "_ready_e19"},   {31'd0, ready},       32'd0);
        to(base + 20);
        chk({tag, "_sys_rst_e20"}, {31'd0, sys_rst_out}, 32'd0);
        chk({tag, "_ready_e20"},   {31'd0, ready},       32'd1);
        chk({tag, "_retry_e20"},   {28'd0, retry_count}, 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        pll_locked_in = 1'b0;
        step();
    endtask

    initial begin
        int n;
        int exp_lost;
        e = 0;
        base = 0;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        pll_locked_in = 1'b0;
        to(3);
        chk_reset_vals("por");

        // Nominal bring-up.
        nominal("nom1");

        // Lock loss in RUN, then re-lock.
        to(base + 30);
        pll_locked_in = 1'b0;
        to(base + 32);
        chk("loss_ready_e32", {31'd0, ready}, 32'd1);
        to(base + 33);
        chk("loss_sys_rst_e33", {31'd0, sys_rst_out}, 32'd1);
        chk("loss_ready_e33",   {31'd0, ready},       32'd0);
        chk("loss_pll_rst_e33", {31'd0, pll_rst_out}, 32'd1);
        chk("loss_lost_e33",    {24'd0, lost_lock_count}, 32'd1);
        to(base + 36);
        chk("loss_pll_rst_e36", {31'd0, pll_rst_out}, 32'd1);
        to(base + 37);
        chk("loss_pll_rst_e37", {31'd0, pll_rst_out}, 32'd0);
        pll_locked_in = 1'b1;
        to(base + 46);
        chk("relock_ready_e46", {31'd0, ready}, 32'd0);
        to(base + 47);
        chk("relock_ready_e47", {31'd0, ready}, 32'd1);

        // Second loss, drive into STABLE, then reset mid-count.
        to(base + 50);
        pll_locked_in = 1'b0;
        to(base + 53);
        chk("loss2_lost", {24'd0, lost_lock_count}, 32'd2);
        to(base + 55);
        pll_locked_in = 1'b1;
        to(base + 60);
        chk("stable_pll_rst", {31'd0, pll_rst_out}, 32'd0);
        chk("stable_sys_rst", {31'd0, sys_rst_out}, 32'd1);
        apply_reset();
        chk_reset_vals("rst_stable");
        nominal("nom2");

        // Lock glitch during STABLE.
        apply_reset();
        base = e;
        rst = 1'b0;
        to(base + 10);
        pll_locked_in = 1'b1;
        to(base + 14);
        pll_locked_in = 1'b0;
        to(base + 15);
        pll_locked_in = 1'b1;
        to(base + 17);
        chk("glitch_pll_rst_e17", {31'd0, pll_rst_out}, 32'd0);
        to(base + 24);
        chk("glitch_ready_e24",   {31'd0, ready},       32'd0);
        chk("glitch_sys_rst_e24", {31'd0, sys_rst_out}, 32'd1);
        chk("glitch_pll_rst_e24", {31'd0, pll_rst_out}, 32'd0);
        chk("glitch_retry_e24",   {28'd0, retry_count}, 32'd0);
        to(base + 25);
        chk("glitch_ready_e25",   {31'd0, ready},       32'd1);

        // Timeouts leading to FAULT.
        apply_reset();
        base = e;
        rst = 1'b0;
        to(base + 23);
        chk("to_retry_e23",   {28'd0, retry_count}, 32'd0);
        chk("to_pll_rst_e23", {31'd0, pll_rst_out}, 32'd0);
        to(base + 24);
        chk("to_retry_e24",   {28'd0, retry_count}, 32'd1);
        chk("to_pll_rst_e24", {31'd0, pll_rst_out}, 32'd1);
        to(base + 27);
        chk("to_pll_rst_e27", {31'd0, pll_rst_out}, 32'd1);
        to(base + 28);
        chk("to_pll_rst_e28", {31'd0, pll_rst_out}, 32'd0);
        to(base + 48);
        chk("to_retry_e48",   {28'd0, retry_count}, 32'd2);
        chk("to_fault_e48",   {31'd0, fault},       32'd0);
        to(base + 71);
        chk("to_fault_e71",   {31'd0, fault},       32'd0);
        to(base + 72);
        chk("to_fault_e72",   {31'd0, fault},       32'd1);
        chk("to_pll_rst_e72", {31'd0, pll_rst_out}, 32'd1);
        chk("to_sys_rst_e72", {31'd0, sys_rst_out}, 32'd1);
        chk("to_retry_e72",   {28'd0, retry_count}, 32'd3);
        pll_locked_in = 1'b1;
        to(base + 90);
        chk("fault_hold_fault", {31'd0, fault},       32'd1);
        chk("fault_hold_ready", {31'd0, ready},       32'd0);
        chk("fault_hold_pll",   {31'd0, pll_rst_out}, 32'd1);
        apply_reset();
        chk_reset_vals("rst_fault");
        nominal("nom3");

        // Saturation of the lock-loss counter.
        exp_lost = 0;
        for (int i = 0; i < 260; i++) begin
            pll_locked_in = 1'b0;
            n = 0;
            while (!sys_rst_out && n < 10) begin
                step();
                n = n + 1;
            end
            chk("sat_loss_seen", {31'd0, sys_rst_out}, 32'd1);
            if (exp_lost < 255) begin
                exp_lost = exp_lost + 1;
            end
            chk("sat_lost", {24'd0, lost_lock_count}, exp_lost);
            pll_locked_in = 1'b1;
            n = 0;
            while (pll_rst_out && n < 20) begin
                step();
                n = n + 1;
            end
            chk("sat_pll_pulse", n, 32'd4);
            n = 0;
            while (!ready && n < 40) begin
                step();
                n = n + 1;
            end
            chk("sat_relock", {31'd0, ready}, 32'd1);
        end
        chk("sat_final", {24'd0, lost_lock_count}, 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
